// File: rtl/led_matrix_scan.sv
// led_matrix_scan
//   Display-side scanner for a 4-column x 8-row RGB block grid. The four
//   colour columns are snapshotted at the start of every frame. The rows are
//   then scanned one at a time. For each row, 12 RGB bits are shifted out to an
//   external SIPO driver chain, the driver latch is pulsed, and the row line is
//   enabled.
//
// Ports
//   CLK_50M      in   system clock, rising edge
//   RST_N        in   synchronous active-low reset
//   scan_en      in   1 = scan, 0 = blank and idle
//   column_0..3  in   24-bit column colours, row r = bits [3r+2:3r] = {R,G,B}
//   sh_data      out  serial colour bit to the driver chain
//   sh_clk       out  shift clock (driver samples on rising edge)
//   sh_latch     out  driver latch strobe, active-high
//   row_sel      out  row enables, active-low, at most one bit low
//   frame_done   out  one-cycle pulse at the end of the row 7 hold
//
// state | meaning
// IDLE  | blanked, row index 0, waiting for scan_en
// LOAD  | one cycle; snapshot the columns on row 0, arm the bit counter
// SHIFT | 12 bits, each CLK_DIV cycles low then CLK_DIV cycles high on sh_clk
// LATCH | rows blanked, sh_latch high for CLK_DIV cycles, then light the row
// HOLD  | row lit for ROW_HOLD cycles, then advance the row
module led_matrix_scan #(
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 50000
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        scan_en,
  input  logic [23:0] column_0,
  input  logic [23:0] column_1,
  input  logic [23:0] column_2,
  input  logic [23:0] column_3,
  output logic        sh_data,
  output logic        sh_clk,
  output logic        sh_latch,
  output logic [7:0]  row_sel,
  output logic        frame_done
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = $clog2(ROW_HOLD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROW_HOLD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic               phase;
  logic [3:0]         bit_cnt;
  logic [2:0]         row;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [3:0][23:0]   frame_buf;
  logic [7:0]         row_lit;
  logic [4:0]         row_ofs;
  logic [11:0]        row_word;
  logic               div_tc;
  logic               hold_tc;

  assign div_tc  = (div_cnt == '0);
  assign hold_tc = (hold_cnt == '0);
  assign row_ofs = {2'b00, row} + {1'b0, row, 1'b0};

  // Word bit 11 is shifted first: column 3 R,G,B down to column 0 B.
  assign row_word = {frame_buf[3][row_ofs +: 3], frame_buf[2][row_ofs +: 3],
                     frame_buf[1][row_ofs +: 3], frame_buf[0][row_ofs +: 3]};

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sh_data    = 1'b0;
    sh_clk     = 1'b0;
    sh_latch   = 1'b0;
    row_sel    = row_lit;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (scan_en) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: begin
        sh_data = row_word[bit_cnt];
        sh_clk  = phase;
        if (div_tc && phase && (bit_cnt == 4'd0)) state_nxt = LATCH;
      end
      LATCH: begin
        sh_latch = 1'b1;
        row_sel  = 8'hFF;
        if (div_tc) state_nxt = HOLD;
      end
      HOLD: begin
        if (hold_tc) begin
          state_nxt  = LOAD;
          frame_done = (row == 3'd7) && scan_en;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!scan_en) state_nxt = IDLE;
  end

  // The datapath is cleared whenever the FSM heads to IDLE. A scan_en drop
  // therefore blanks the rows on the very next edge, and a later restart
  // begins on row 0.
  always_ff @(posedge CLK_50M) begin
    if (!RST_N || (state_nxt == IDLE)) begin
      div_cnt  <= DIV_LAST;
      phase    <= 1'b0;
      bit_cnt  <= 4'd11;
      row      <= 3'd0;
      hold_cnt <= HOLD_LAST;
      row_lit  <= 8'hFF;
    end else begin
      case (state)
        LOAD: begin
          if (row == 3'd0) frame_buf <= {column_3, column_2, column_1, column_0};
          bit_cnt <= 4'd11;
          div_cnt <= DIV_LAST;
          phase   <= 1'b0;
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= DIV_LAST;
            phase   <= ~phase;
            if (phase && (bit_cnt != 4'd0)) bit_cnt <= bit_cnt - 4'd1;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        LATCH: begin
          if (div_tc) begin
            div_cnt  <= DIV_LAST;
            hold_cnt <= HOLD_LAST;
            row_lit  <= ~(8'd1 << row);
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (hold_tc) row      <= row + 3'd1;
          else         hold_cnt <= hold_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan
//   Directed bench for led_matrix_scan with CLK_DIV=4 and ROW_HOLD=100,
//   which gives 201 cycles per row and 1608 cycles per frame.
//   A negedge monitor reassembles each row's 12-bit stream and counts the
//   sh_clk edges in each row.
module tb_led_matrix_scan;

  localparam int CLK_DIV  = 4;
  localparam int ROW_HOLD = 100;

  logic        CLK_50M = 1'b0;
  logic        RST_N;
  logic        scan_en;
  logic [23:0] column_0, column_1, column_2, column_3;
  logic        sh_data, sh_clk, sh_latch, frame_done;
  logic [7:0]  row_sel;

  led_matrix_scan #(.CLK_DIV(CLK_DIV), .ROW_HOLD(ROW_HOLD)) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N), .scan_en(scan_en),
    .column_0(column_0), .column_1(column_1), .column_2(column_2), .column_3(column_3),
    .sh_data(sh_data), .sh_clk(sh_clk), .sh_latch(sh_latch),
    .row_sel(row_sel), .frame_done(frame_done)
  );

  always #10 CLK_50M = ~CLK_50M;

  int checks = 0;
  int errors = 0;

  // Stream monitor.
  logic [11:0] shreg = '0;
  logic [11:0] row_words [8];
  int          edges_cap [8];
  int          edge_cnt = 0;
  int          latch_cnt = 0;
  logic        prev_clk = 1'b0;
  logic        prev_latch = 1'b0;
  logic [2:0]  slot;

  always @(negedge CLK_50M) begin
    if (!scan_en || !RST_N) begin
      latch_cnt = 0;
      edge_cnt  = 0;
      shreg     = '0;
    end else begin
      if (sh_clk && !prev_clk) begin
        shreg    = {shreg[10:0], sh_data};
        edge_cnt = edge_cnt + 1;
      end
      if (sh_latch && !prev_latch) begin
        slot            = latch_cnt[2:0];
        row_words[slot] = shreg;
        edges_cap[slot] = edge_cnt;
        edge_cnt        = 0;
        latch_cnt       = latch_cnt + 1;
      end
    end
    prev_clk   = sh_clk;
    prev_latch = sh_latch;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_latch(input int n, input string name);
    int k = 0;
    while (latch_cnt < n && k < 4000) begin
      @(negedge CLK_50M);
      k++;
    end
    checks++;
    if (latch_cnt < n) begin
      errors++;
      $display("FAIL %s: timeout, latches %0d expected %0d", name, latch_cnt, n);
    end
  endtask

  task automatic start_scan();
    scan_en = 1'b0;
    @(negedge CLK_50M);
    @(negedge CLK_50M);
    scan_en = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [23:0] c0, c1, c2, c3;
    int          row;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs [9];
  logic [7:0]  exp_rs [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"px_r0",    24'h000004, 24'h0,      24'h0,      24'h0,      0, 12'h004};
    vecs[1] = '{"px_r1",    24'h000004, 24'h0,      24'h0,      24'h0,      1, 12'h000};
    vecs[2] = '{"px_r7",    24'h000004, 24'h0,      24'h0,      24'h0,      7, 12'h000};
    vecs[3] = '{"c3b_r0",   24'h0,      24'h0,      24'h0,      24'h000001, 0, 12'h200};
    vecs[4] = '{"c1_r1",    24'h0,      24'h000038, 24'h0,      24'h0,      1, 12'h038};
    vecs[5] = '{"c2_r7",    24'h0,      24'h0,      24'hE00000, 24'h0,      7, 12'h1C0};
    vecs[6] = '{"mix_r0",   24'h123456, 24'h0,      24'h0,      24'h654321, 0, 12'h206};
    vecs[7] = '{"mix_r2",   24'h123456, 24'h0,      24'h0,      24'h654321, 2, 12'h801};
    vecs[8] = '{"white_r5", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 5, 12'hFFF};
    exp_rs = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    // Reset dominates scan_en.
    RST_N = 1'b0; scan_en = 1'b1;
    column_0 = '0; column_1 = '0; column_2 = '0; column_3 = '0;
    repeat (3) @(negedge CLK_50M);
    chk("reset_outputs", 32'({sh_data, sh_clk, sh_latch, frame_done, row_sel}), 32'h0FF);
    RST_N = 1'b1;

    // Table-driven row streams.
    for (int i = 0; i < 9; i++) begin
      scan_en = 1'b0;
      column_0 = vecs[i].c0; column_1 = vecs[i].c1;
      column_2 = vecs[i].c2; column_3 = vecs[i].c3;
      start_scan();
      wait_latch(vecs[i].row + 1, {vecs[i].name, "_wait"});
      chk(vecs[i].name, 32'(row_words[vecs[i].row]), 32'(vecs[i].exp));
    end

    // All-white: every row is 12 ones clocked by 12 rising edges.
    start_scan();
    wait_latch(8, "white_wait");
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("white_word_r%0d", r), 32'(row_words[r]), 32'hFFF);
      chk($sformatf("white_edges_r%0d", r), 32'(edges_cap[r]), 32'd12);
    end

    // Row sequence, row period and frame_done over two frames.
    begin
      logic [7:0] seq [16];
      int         seq_t [16];
      int         fd_t [4];
      int         n_rs, n_fd, fd_hi, multi_low;
      logic [7:0] prev_rs;
      logic       prev_fd;
      n_rs = 0; n_fd = 0; fd_hi = 0; multi_low = 0;
      prev_rs = 8'hFF; prev_fd = 1'b0;
      column_0 = 24'h000004; column_1 = '0; column_2 = '0; column_3 = '0;
      start_scan();
      for (int c = 1; c <= 3500; c++) begin
        @(negedge CLK_50M);
        if (row_sel != prev_rs && row_sel != 8'hFF && n_rs < 16) begin
          seq[n_rs] = row_sel; seq_t[n_rs] = c; n_rs++;
        end
        if ($countones(~row_sel) > 1) multi_low++;
        if (frame_done) fd_hi++;
        if (frame_done && !prev_fd && n_fd < 4) begin
          fd_t[n_fd] = c; n_fd++;
        end
        prev_rs = row_sel; prev_fd = frame_done;
      end
      chk("row_enable_count", 32'(n_rs), 32'd16);
      for (int k = 0; k < n_rs; k++)
        chk($sformatf("row_sel_seq_%0d", k), 32'(seq[k]), 32'(exp_rs[k % 8]));
      for (int k = 1; k < n_rs; k++)
        chk($sformatf("row_period_%0d", k), 32'(seq_t[k] - seq_t[k-1]), 32'd201);
      chk("one_row_max", 32'(multi_low), 32'd0);
      chk("frame_done_count", 32'(n_fd), 32'd2);
      if (n_fd >= 2) chk("frame_period", 32'(fd_t[1] - fd_t[0]), 32'd1608);
      chk("frame_done_width", 32'(fd_hi), 32'(n_fd));
    end

    // Snapshot: column_3 changes during row 2 hold / row 3 shift.
    column_0 = '0; column_1 = '0; column_2 = '0; column_3 = '0;
    start_scan();
    wait_latch(3, "snap_wait_a");
    column_3 = 24'hFFFFFF;
    wait_latch(8, "snap_wait_b");
    for (int r = 3; r < 8; r++)
      chk($sformatf("snap_old_r%0d", r), 32'(row_words[r]), 32'h000);
    wait_latch(16, "snap_wait_c");
    for (int r = 0; r < 8; r++)
      chk($sformatf("snap_new_r%0d", r), 32'(row_words[r]), 32'hE00);

    // Abort during LATCH, then restart from row 0.
    begin
      int k;
      column_0 = 24'h000004; column_3 = '0;
      start_scan();
      k = 0;
      while (!sh_latch && k < 400) begin
        @(negedge CLK_50M);
        k++;
      end
      chk("abort_reach_latch", 32'(sh_latch), 32'd1);
      scan_en = 1'b0;
      @(negedge CLK_50M);
      chk("abort_latch_low", 32'(sh_latch), 32'd0);
      chk("abort_rows_off", 32'(row_sel), 32'hFF);
      @(negedge CLK_50M);
      scan_en = 1'b1;
      wait_latch(1, "abort_restart_wait");
      repeat (5) @(negedge CLK_50M);
      chk("abort_restart_row", 32'(row_sel), 32'hFE);
      chk("abort_restart_word", 32'(row_words[0]), 32'h004);
    end

    // Reset mid-SHIFT for 3 cycles, then restart at row 0.
    begin
      int k;
      wait_latch(2, "rst_wait_row2");
      k = 0;
      while (!sh_clk && k < 400) begin
        @(negedge CLK_50M);
        k++;
      end
      chk("rst_reach_shift", 32'(sh_clk), 32'd1);
      RST_N = 1'b0;
      @(negedge CLK_50M);
      chk("rst_mid_shift", 32'({sh_data, sh_clk, sh_latch, frame_done, row_sel}), 32'h0FF);
      @(negedge CLK_50M);
      @(negedge CLK_50M);
      chk("rst_held", 32'(row_sel), 32'hFF);
      RST_N = 1'b1;
      k = 0;
      do begin
        @(negedge CLK_50M);
        k++;
      end while (!sh_clk && k < 50);
      chk("rst_first_sh_clk", 32'(k), 32'd6);
      wait_latch(1, "rst_restart_wait");
      repeat (5) @(negedge CLK_50M);
      chk("rst_restart_row", 32'(row_sel), 32'hFE);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
